// File: rtl/clock_pkg.sv
// Shared definitions for the time-entry block: FSM states, field codes,
// range limits and the saturating clamp used when confirming a field.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    localparam logic [1:0] FIELD_NONE    = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;
    localparam logic [1:0] FIELD_SECONDS = 2'd3;

    localparam logic [5:0] MAX_HOUR    = 6'd23;
    localparam logic [5:0] MAX_MIN_SEC = 6'd59;

    // Clamp on the full 6-bit switch value so that e.g. 63 becomes 23, not 31.
    function automatic logic [5:0] sat6(input logic [5:0] val, input logic [5:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Key conditioner: 2-flop synchronizer, consecutive-cycle debouncer and a
// single-cycle press pulse. Keys are active-low; released level is 1.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive mismatch cycles; any agreeing cycle restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = {CW{1'b0}};
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = {CW{1'b0}};
                press_d = ~sync2_q;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Synchronizer and debounce state; reset returns everything to released.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= {CW{1'b0}};
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/time_entry.sv
// Time-of-day entry: walks hours/minutes/seconds from the switches, clamps
// each field, then offers the staged time on a valid/ready handshake.
module time_entry
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLINK_HALF      = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_next_n,
    input  logic       key_cancel_n,
    input  logic [5:0] sw,
    input  logic       load_ready,
    output logic       load_valid,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] field,
    output logic       blink
);

    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    logic          next_ev_s;
    logic          cancel_ev_s;
    logic [5:0]    hsat_s;
    logic [5:0]    msat_s;

    state_e        state_q;
    state_e        state_d;
    logic [4:0]    hours_q;
    logic [4:0]    hours_d;
    logic [5:0]    minutes_q;
    logic [5:0]    minutes_d;
    logic [5:0]    seconds_q;
    logic [5:0]    seconds_d;
    logic [1:0]    field_q;
    logic [1:0]    field_d;
    logic          load_valid_q;
    logic          load_valid_d;
    logic          blink_q;
    logic          blink_d;
    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_next_n),
        .press (next_ev_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_cancel_n),
        .press (cancel_ev_s)
    );

    assign hsat_s = sat6(sw, MAX_HOUR);
    assign msat_s = sat6(sw, MAX_MIN_SEC);

    // Next-state and field latching; cancel beats next, keys are ignored in COMMIT.
    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        case (state_q)
            ST_IDLE: begin
                if (next_ev_s && !cancel_ev_s) begin
                    state_d = ST_SET_H;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SET_H: begin
                if (cancel_ev_s) begin
                    state_d = ST_IDLE;
                end else if (next_ev_s) begin
                    hours_d = 5'(hsat_s);
                    state_d = ST_SET_M;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SET_M: begin
                if (cancel_ev_s) begin
                    state_d = ST_IDLE;
                end else if (next_ev_s) begin
                    minutes_d = msat_s;
                    state_d   = ST_SET_S;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SET_S: begin
                if (cancel_ev_s) begin
                    state_d = ST_IDLE;
                end else if (next_ev_s) begin
                    seconds_d = msat_s;
                    state_d   = ST_COMMIT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMMIT: begin
                if (load_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs derived from the next state, plus the blink divider.
    always_comb begin
        field_d      = FIELD_NONE;
        load_valid_d = (state_d == ST_COMMIT);
        blink_d      = 1'b0;
        blink_cnt_d  = {BW{1'b0}};
        case (state_d)
            ST_SET_H: field_d = FIELD_HOURS;
            ST_SET_M: field_d = FIELD_MINUTES;
            ST_SET_S: field_d = FIELD_SECONDS;
            default:  field_d = FIELD_NONE;
        endcase
        if (state_d != state_q) begin
            blink_d     = 1'b0;
            blink_cnt_d = {BW{1'b0}};
        end else if (field_d != FIELD_NONE) begin
            if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
                blink_cnt_d = {BW{1'b0}};
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_d     = blink_q;
            end
        end else begin
            blink_d     = 1'b0;
            blink_cnt_d = {BW{1'b0}};
        end
    end

    // FSM state, staged time and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hours_q      <= 5'd0;
            minutes_q    <= 6'd0;
            seconds_q    <= 6'd0;
            field_q      <= FIELD_NONE;
            load_valid_q <= 1'b0;
            blink_q      <= 1'b0;
            blink_cnt_q  <= {BW{1'b0}};
        end else begin
            state_q      <= state_d;
            hours_q      <= hours_d;
            minutes_q    <= minutes_d;
            seconds_q    <= seconds_d;
            field_q      <= field_d;
            load_valid_q <= load_valid_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign load_valid = load_valid_q;
    assign hours      = hours_q;
    assign minutes    = minutes_q;
    assign seconds    = seconds_q;
    assign field      = field_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_time_entry.sv
// Randomized scoreboard bench for time_entry with a step-level reference model.
module tb_time_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_next_n = 1'b1;
    logic       key_cancel_n = 1'b1;
    logic [5:0] sw = 6'd0;
    logic       load_ready = 1'b0;
    logic       load_valid;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] field;
    logic       blink;

    time_entry #(.DEBOUNCE_CYCLES(4), .BLINK_HALF(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_next_n   (key_next_n),
        .key_cancel_n (key_cancel_n),
        .sw           (sw),
        .load_ready   (load_ready),
        .load_valid   (load_valid),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .field        (field),
        .blink        (blink)
    );

    always #5 clk = ~clk;

    typedef struct { int h; int m; int s; } tv_t;
    tv_t exp_q[$];
    tv_t mon_e;

    int n_vec = 0;
    int n_err = 0;
    int hs_seen = 0;
    int lv_cycles = 0;

    // Reference model: step 0 idle, 1 hours, 2 minutes, 3 seconds, 4 waiting to load.
    int m_step = 0;
    int m_h = 0, m_m = 0, m_s = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Monitor: every accepted load must match the oldest predicted commit.
    always @(negedge clk) begin
        if (!rst && load_valid) lv_cycles++;
        if (!rst && load_valid && load_ready) begin
            hs_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_load", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("load_hours", int'(hours), mon_e.h);
                chk("load_minutes", int'(minutes), mon_e.m);
                chk("load_seconds", int'(seconds), mon_e.s);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input bit nx, input bit cx, input int v);
        if (m_step == 4) return;
        if (cx) begin
            m_step = 0;
            return;
        end
        if (!nx) return;
        case (m_step)
            0: m_step = 1;
            1: begin m_h = imin(v, 23); m_step = 2; end
            2: begin m_m = imin(v, 59); m_step = 3; end
            3: begin
                m_s = imin(v, 59);
                exp_q.push_back('{m_h, m_m, m_s});
                m_step = load_ready ? 0 : 4;
            end
            default: m_step = 0;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        int ef;
        ef = (m_step >= 1 && m_step <= 3) ? m_step : 0;
        @(negedge clk);
        chk({tag, "_field"}, int'(field), ef);
        chk({tag, "_load_valid"}, int'(load_valid), (m_step == 4) ? 1 : 0);
        chk({tag, "_hours"}, int'(hours), m_h);
        chk({tag, "_minutes"}, int'(minutes), m_m);
        chk({tag, "_seconds"}, int'(seconds), m_s);
        if (ef == 0) chk({tag, "_blink_off"}, int'(blink), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit nx, input bit cx, input int v, input int hold, input string tag);
        sw = 6'(v);
        model_apply(nx, cx, v);
        key_next_n = ~nx;
        key_cancel_n = ~cx;
        tick(hold);
        key_next_n = 1'b1;
        key_cancel_n = 1'b1;
        tick(12);
        check_outputs(tag);
    endtask

    task automatic bounce(input int reps);
        repeat (reps) begin
            key_next_n = 1'b0;
            tick(3);
            key_next_n = 1'b1;
            tick(1);
        end
        tick(12);
        check_outputs("bounce");
    endtask

    task automatic accept();
        int k;
        load_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (load_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept_done", int'(load_valid), 0);
        if (m_step == 4) m_step = 0;
        @(posedge clk);
        #1;
        load_ready = 1'b0;
    endtask

    task automatic wait_field(input int want, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (int'(field) != want && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_field_reached"}, int'(field), want);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int lv0;
        int r;
        // Reset state
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_load_valid", int'(load_valid), 0);
        chk("rst_hours", int'(hours), 0);
        chk("rst_minutes", int'(minutes), 0);
        chk("rst_seconds", int'(seconds), 0);
        chk("rst_field", int'(field), 0);
        chk("rst_blink", int'(blink), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        // Full entry with one handshake
        press(1, 0, 0, 10, "entry_start");
        press(1, 0, 14, 10, "entry_h");
        press(1, 0, 35, 10, "entry_m");
        press(1, 0, 7, 10, "entry_s");
        hs0 = hs_seen;
        accept();
        chk("entry_one_handshake", hs_seen - hs0, 1);
        check_outputs("entry_after");

        // Saturation on every field
        press(1, 0, 0, 10, "sat_start");
        press(1, 0, 63, 10, "sat_h");
        press(1, 0, 63, 10, "sat_m");
        press(1, 0, 63, 10, "sat_s");
        accept();

        // Bounce gives nothing; exactly 4 stable cycles gives one event
        bounce(30);
        press(1, 0, 0, 4, "stable4");
        lv0 = lv_cycles;
        press(1, 0, 10, 1000, "hold1000");
        press(0, 1, 0, 10, "cancel_setm");
        chk("cancel_no_load_valid", lv_cycles - lv0, 0);

        // Simultaneous next+cancel in SET_M
        press(1, 0, 0, 10, "both_start");
        press(1, 0, 3, 10, "both_h");
        press(1, 1, 20, 10, "both_cancel");

        // COMMIT stall while both keys pressed
        press(1, 0, 0, 10, "stall_start");
        press(1, 0, 1, 10, "stall_h");
        press(1, 0, 2, 10, "stall_m");
        press(1, 0, 3, 10, "stall_s");
        key_next_n = 1'b0;
        key_cancel_n = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("stall_load_valid", int'(load_valid), 1);
            chk("stall_seconds", int'(seconds), 3);
        end
        @(posedge clk);
        #1;
        key_next_n = 1'b1;
        key_cancel_n = 1'b1;
        tick(12);
        check_outputs("stall_after");
        accept();

        // Blink: 16-cycle period in SET_H, 0 on each field entry
        sw = 6'd5;
        model_apply(1, 0, 5);
        key_next_n = 1'b0;
        wait_field(1, "blink_h");
        for (int i = 0; i < 32; i++) begin
            chk("blink_wave", int'(blink), (i / 8) % 2);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        key_next_n = 1'b1;
        tick(12);
        model_apply(1, 0, 5);
        key_next_n = 1'b0;
        wait_field(2, "blink_m");
        chk("blink_new_field", int'(blink), 0);
        @(posedge clk);
        #1;
        key_next_n = 1'b1;
        tick(12);
        check_outputs("blink_after");
        press(0, 1, 0, 10, "blink_cancel");

        // Randomized operations
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) press(1, 0, $urandom_range(0, 63), 10, "rnd_next");
            else if (r == 6) press(0, 1, $urandom_range(0, 63), 10, "rnd_cancel");
            else if (r == 7) press(1, 1, $urandom_range(0, 63), 10, "rnd_both");
            else if (r == 8) bounce(5);
            else if (m_step == 4) accept();
            else load_ready = 1'($urandom_range(0, 1));
        end
        if (m_step == 4) accept();
        load_ready = 1'b0;
        tick(2);

        // Reset while in COMMIT drops the offer
        for (int k = 0; k < 5 && m_step != 4; k++) press(1, 0, 9, 10, "pre_rst");
        check_outputs("pre_rst_commit");
        hs0 = hs_seen;
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        chk("rstc_load_valid", int'(load_valid), 0);
        chk("rstc_hours", int'(hours), 0);
        chk("rstc_minutes", int'(minutes), 0);
        chk("rstc_seconds", int'(seconds), 0);
        chk("rstc_field", int'(field), 0);
        chk("rstc_blink", int'(blink), 0);
        chk("rstc_no_load", hs_seen - hs0, 0);
        exp_q.delete();
        m_step = 0; m_h = 0; m_m = 0; m_s = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(3);
        check_outputs("post_rst");

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles before a key level is accepted (10 ms at 50 MHz).
REQ-002 Parameter BLINK_HALF, default 12500000, cycles per blink half-period.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_next_n  input  1  raw, asynchronous, active-low advance/confirm key.
REQ-006 key_cancel_n  input  1  raw, asynchronous, active-low abort key.
REQ-007 sw  input  6  binary value for the field being edited.
REQ-008 load_ready  input  1  time-keeper accepts the staged time.
REQ-009 load_valid  output  1  staged time is offered for loading.
REQ-010 hours  output  5  staged hours, 0..23.
REQ-011 minutes  output  6  staged minutes, 0..59.
REQ-012 seconds  output  6  staged seconds, 0..59.
REQ-013 field  output  2  field being edited: 0 none, 1 hours, 2 minutes, 3 seconds.
REQ-014 blink  output  1  display blank strobe for the field being edited.

Function
REQ-015 Each key SHALL pass through a 2-flop synchronizer followed by the debouncer.
- Debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any mismatch gap restarts the count.
REQ-016 A press event SHALL be a one-cycle pulse in the cycle the debounced level becomes pressed.
- Release produces no event.
- A held key produces exactly one event.
REQ-017 FSM states SHALL be IDLE, SET_H, SET_M, SET_S, COMMIT.
- Transitions occur on the clock edge after the event pulse.
REQ-018 IDLE + next -> SET_H; staged values are unchanged.
REQ-019 SET_H + next: hours <= min(sw, 23) -> SET_M.
REQ-020 SET_M + next: minutes <= min(sw, 59) -> SET_S.
REQ-021 SET_S + next: seconds <= min(sw, 59) -> COMMIT.
REQ-022 Saturation SHALL compare the full 6-bit sw before truncating to the output width; e.g. sw=63 in SET_H yields hours=23, not 31.
REQ-023 In COMMIT, load_valid SHALL be 1 with hours/minutes/seconds held stable.
- Handshake completes on the first edge where load_valid and load_ready are both 1.
- FSM then goes to IDLE and load_valid is 0 the following cycle.
REQ-024 load_ready SHALL be ignored outside COMMIT.
- load_ready already high on COMMIT entry completes the handshake on the first COMMIT cycle.
REQ-025 Cancel in SET_H/SET_M/SET_S SHALL return to IDLE and keep every field already latched in this pass.
REQ-026 Next and cancel events in the same cycle: cancel wins.
REQ-027 All key events SHALL be ignored in COMMIT and cancel SHALL be ignored in IDLE.
REQ-028 field SHALL be 1/2/3 in SET_H/SET_M/SET_S, else 0.
REQ-029 blink SHALL toggle every BLINK_HALF cycles while in a SET state.
- blink is forced to 0 in IDLE and COMMIT.
- The blink counter clears on every state change, so each new field starts with blink=0.

Reset
REQ-030 rst SHALL take effect at the next clock edge: state IDLE; hours=minutes=seconds=0; load_valid=0; field=0; blink=0.
REQ-031 rst SHALL also clear debounce counters and synchronizers to the released level, and clear the blink counter.
- Reset mid-COMMIT drops load_valid with no completed load.

Structure
REQ-032 Shared package clock_pkg SHALL hold the state enum, field encoding constants, MAX_HOUR=23 and MAX_MIN_SEC=59.
REQ-033 Sub-module btn_debounce (synchronizer + debounce counter + press pulse) SHALL be instantiated once per key.
REQ-034 The FSM, saturation and blink divider SHALL reside in time_entry.

Verification (DEBOUNCE_CYCLES=4, BLINK_HALF=8)
REQ-035 Full entry: next; sw=14 next; sw=35 next; sw=7 next; load_ready=1.
- Required: load_valid=1 with 14/35/07; one handshake; then IDLE with load_valid=0.
REQ-036 Saturation: sw=63 confirmed in each of SET_H, SET_M, SET_S.
- Required: hours=23, minutes=59, seconds=59.
REQ-037 Bounce: key_next_n pulses low 3 cycles, high 1 cycle, repeatedly.
- Required: no event.
- A 4-cycle stable low yields exactly one event; holding 1000 cycles yields no second event.
REQ-038 Cancel in SET_M after hours=10: IDLE, field=0, hours=10, load_valid never asserted.
- Simultaneous next+cancel: cancel wins.
REQ-039 COMMIT with load_ready=0 for 50 cycles while next and cancel are pressed: load_valid stays 1, values stable, state stays COMMIT.
REQ-040 Blink and reset: in SET_H, blink period is 16 cycles, and blink=0 right after each field change.
- rst asserted in COMMIT: all outputs 0 the next cycle.
